// File: rtl/io_fabric_pkg.sv
// Shared constants and types for the nano6502 IO bus fabric: register offsets,
// ROM window bounds, read-source select and wait-state FSM encodings.
package io_fabric_pkg;

    localparam logic [15:0] REG_BANK_L = 16'h0000;
    localparam logic [15:0] REG_BANK_H = 16'h0001;
    localparam logic [15:0] REG_ROMCTL = 16'h0002;
    localparam logic [15:0] REG_STATUS = 16'h0003;

    localparam logic [15:0] ROM_LO   = 16'hE000;
    localparam logic [15:0] ROM_HI   = 16'hFDFF;
    localparam logic [7:0]  VEC_PAGE = 8'hFF;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_ROM,
        SEL_REG,
        SEL_SLOT,
        SEL_UNMAPPED
    } sel_e;

    typedef enum logic {
        WS_IDLE,
        WS_WAIT
    } wait_state_e;

    function automatic logic in_rom_window(input logic [15:0] addr);
        return (addr >= ROM_LO) && (addr <= ROM_HI);
    endfunction

endpackage

// File: rtl/io_wait_ctrl.sv
// Per-access wait-state generator: a start pulse with a non-zero count n holds
// rdy_o low for exactly n cycles, beginning the cycle after the start.
module io_wait_ctrl
    import io_fabric_pkg::*;
#(
    parameter int WAIT_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WAIT_W-1:0] n_i,
    output logic              rdy_o
);

    wait_state_e       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WS_IDLE: begin
                if (start_i && (n_i != '0)) begin
                    state_d = WS_WAIT;
                    cnt_d   = n_i;
                end
            end
            WS_WAIT: begin
                // The count is never decremented past 1, so it cannot wrap.
                if (cnt_q == WAIT_W'(1)) begin
                    state_d = WS_IDLE;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    always_comb begin
        rdy_o = (state_q == WS_IDLE);
    end

endmodule

// File: rtl/io_fabric.sv
// nano6502 IO bus fabric: RAM/ROM/banked-slot decode, fabric registers and a
// registered read mux. Per-slot wait states are built only with IO_FABRIC_WAIT_EN.
module io_fabric
    import io_fabric_pkg::*;
#(
    parameter int                        N_SLOTS   = 8,
    parameter int                        WAIT_W    = 3,
    parameter logic [N_SLOTS*WAIT_W-1:0] SLOT_WAIT = '0,
    parameter logic [7:0]                IO_PAGE   = 8'hFE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [15:0]          cpu_addr_i,
    input  logic                 cpu_we_i,
    input  logic [7:0]           cpu_wdata_i,
    output logic [7:0]           cpu_rdata_o,
    output logic                 cpu_rdy_o,
    output logic                 ram_cs_o,
    input  logic [7:0]           ram_rdata_i,
    output logic                 rom_cs_o,
    input  logic [7:0]           rom_rdata_i,
    output logic [N_SLOTS-1:0]   slot_cs_o,
    output logic                 slot_we_o,
    output logic [7:0]           slot_addr_o,
    output logic [7:0]           slot_wdata_o,
    input  logic [N_SLOTS*8-1:0] slot_rdata_i,
    output logic                 rom_en_o
);

    logic               rdy;
    logic               start;
    logic               reg_hit, vec_hit, io_hit, rom_win, bank_mapped;
    logic [N_SLOTS-1:0] slot_dec;
    sel_e               sel_d, sel_q;

    logic [15:0]        bank_d, bank_q;
    logic               romctl_d, romctl_q;
    logic               status_d, status_q;
    logic [7:0]         reg_rdata_d, reg_rdata_q;
    logic [N_SLOTS-1:0] slot_cs_d, slot_cs_q;
    logic               slot_we_d, slot_we_q;
    logic [7:0]         slot_addr_d, slot_addr_q;
    logic [7:0]         slot_wdata_d, slot_wdata_q;
    logic [7:0]         slot_rd;

    // A cycle with RDY high presents a new access; while RDY is low the CPU
    // is re-presenting the same address and must not re-trigger side effects.
    assign start = rdy;

    always_comb begin
        reg_hit     = (cpu_addr_i[15:2] == REG_BANK_L[15:2]);
        vec_hit     = (cpu_addr_i[15:8] == VEC_PAGE);
        io_hit      = !vec_hit && (cpu_addr_i[15:8] == IO_PAGE);
        rom_win     = in_rom_window(cpu_addr_i);
        bank_mapped = (bank_q < 16'(N_SLOTS));
    end

    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_dec
        assign slot_dec[gi] = io_hit && (bank_q == 16'(gi));
    end

    always_comb begin
        sel_d = SEL_RAM;
        if (reg_hit) begin
            sel_d = SEL_REG;
        end else if (vec_hit) begin
            sel_d = SEL_ROM;
        end else if (io_hit) begin
            sel_d = bank_mapped ? SEL_SLOT : SEL_UNMAPPED;
        end else if (rom_win && !romctl_q) begin
            sel_d = SEL_ROM;
        end
    end

    // Register writes are mirrored into RAM so shadow copies stay coherent.
    assign ram_cs_o = (sel_d == SEL_RAM) || (reg_hit && cpu_we_i);
    assign rom_cs_o = (sel_d == SEL_ROM);

    always_comb begin
        bank_d       = bank_q;
        romctl_d     = romctl_q;
        status_d     = status_q;
        reg_rdata_d  = 8'h00;
        slot_cs_d    = slot_dec;
        slot_we_d    = start && cpu_we_i && (|slot_dec);
        slot_addr_d  = cpu_addr_i[7:0];
        slot_wdata_d = cpu_wdata_i;

        case (cpu_addr_i[1:0])
            REG_BANK_L[1:0]: reg_rdata_d = bank_q[7:0];
            REG_BANK_H[1:0]: reg_rdata_d = bank_q[15:8];
            REG_ROMCTL[1:0]: reg_rdata_d = {7'b0, romctl_q};
            REG_STATUS[1:0]: reg_rdata_d = {7'b0, status_q};
            default:         reg_rdata_d = 8'h00;
        endcase

        if (start && cpu_we_i && reg_hit) begin
            case (cpu_addr_i[1:0])
                REG_BANK_L[1:0]: bank_d[7:0]  = cpu_wdata_i;
                REG_BANK_H[1:0]: bank_d[15:8] = cpu_wdata_i;
                REG_ROMCTL[1:0]: romctl_d     = cpu_wdata_i[0];
                REG_STATUS[1:0]: if (cpu_wdata_i[0]) status_d = 1'b0;
                default:         ;
            endcase
        end

        // Setting after clearing lets a new unmapped access win over W1C.
        if (start && io_hit && !bank_mapped) begin
            status_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q       <= '0;
            romctl_q     <= 1'b0;
            status_q     <= 1'b0;
            reg_rdata_q  <= '0;
            sel_q        <= SEL_RAM;
            slot_cs_q    <= '0;
            slot_we_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
        end else begin
            bank_q       <= bank_d;
            romctl_q     <= romctl_d;
            status_q     <= status_d;
            reg_rdata_q  <= reg_rdata_d;
            sel_q        <= sel_d;
            slot_cs_q    <= slot_cs_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
        end
    end

    always_comb begin
        slot_rd = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_cs_q[k]) begin
                slot_rd = slot_rd | slot_rdata_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        case (sel_q)
            SEL_RAM:      cpu_rdata_o = ram_rdata_i;
            SEL_ROM:      cpu_rdata_o = rom_rdata_i;
            SEL_REG:      cpu_rdata_o = reg_rdata_q;
            SEL_SLOT:     cpu_rdata_o = slot_rd;
            SEL_UNMAPPED: cpu_rdata_o = 8'hFF;
            default:      cpu_rdata_o = 8'hFF;
        endcase
    end

`ifdef IO_FABRIC_WAIT_EN
    logic [WAIT_W-1:0] wait_n;

    always_comb begin
        wait_n = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_dec[k]) begin
                wait_n = wait_n | SLOT_WAIT[k*WAIT_W +: WAIT_W];
            end
        end
    end

    io_wait_ctrl #(
        .WAIT_W (WAIT_W)
    ) u_wait (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (|slot_dec),
        .n_i     (wait_n),
        .rdy_o   (rdy)
    );
`else
    // Without wait states every access completes in one cycle.
    logic unused_slot_wait;
    assign unused_slot_wait = ^SLOT_WAIT;
    assign rdy = 1'b1;
`endif

    assign cpu_rdy_o    = rdy;
    assign slot_cs_o    = slot_cs_q;
    assign slot_we_o    = slot_we_q;
    assign slot_addr_o  = slot_addr_q;
    assign slot_wdata_o = slot_wdata_q;
    assign rom_en_o     = !romctl_q;

endmodule

// File: tb/tb_io_fabric.sv
// Directed bench for io_fabric: decode, fabric registers, banked slots,
// unmapped banks, wait states (when IO_FABRIC_WAIT_EN is defined) and reset.
module tb_io_fabric;

    localparam int          N_SLOTS   = 8;
    localparam int          WAIT_W    = 3;
    // slot 2 waits 3 cycles, slot 5 waits the maximum of 7
    localparam logic [23:0] SLOT_WAIT = 24'h0380C0;
`ifdef IO_FABRIC_WAIT_EN
    localparam int   EXP_W2  = 3;
    localparam int   EXP_W5  = 7;
    localparam logic EXP_MID = 1'b0;
`else
    localparam int   EXP_W2  = 0;
    localparam int   EXP_W5  = 0;
    localparam logic EXP_MID = 1'b1;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [15:0]          cpu_addr_i = '0;
    logic                 cpu_we_i = 1'b0;
    logic [7:0]           cpu_wdata_i = '0;
    logic [7:0]           cpu_rdata_o;
    logic                 cpu_rdy_o;
    logic                 ram_cs_o;
    logic [7:0]           ram_rdata_i = 8'h11;
    logic                 rom_cs_o;
    logic [7:0]           rom_rdata_i = 8'h22;
    logic [N_SLOTS-1:0]   slot_cs_o;
    logic                 slot_we_o;
    logic [7:0]           slot_addr_o;
    logic [7:0]           slot_wdata_o;
    logic [N_SLOTS*8-1:0] slot_rdata_i;
    logic                 rom_en_o;

    int total = 0;
    int bad   = 0;

    io_fabric #(
        .N_SLOTS   (N_SLOTS),
        .WAIT_W    (WAIT_W),
        .SLOT_WAIT (SLOT_WAIT),
        .IO_PAGE   (8'hFE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_rdy_o    (cpu_rdy_o),
        .ram_cs_o     (ram_cs_o),
        .ram_rdata_i  (ram_rdata_i),
        .rom_cs_o     (rom_cs_o),
        .rom_rdata_i  (rom_rdata_i),
        .slot_cs_o    (slot_cs_o),
        .slot_we_o    (slot_we_o),
        .slot_addr_o  (slot_addr_o),
        .slot_wdata_o (slot_wdata_o),
        .slot_rdata_i (slot_rdata_i),
        .rom_en_o     (rom_en_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put(input logic [15:0] a, input logic w, input logic [7:0] d);
        cpu_addr_i  = a;
        cpu_we_i    = w;
        cpu_wdata_i = d;
        $display("txn t=%0t addr=%h we=%b wdata=%h", $time, a, w, d);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        put(a, 1'b1, d);
        step();
        cpu_we_i = 1'b0;
    endtask

    // Holds the address while RDY is low, counting stalled cycles and strobes.
    task automatic slot_access(input string tag, input logic [15:0] a, input logic w,
                               input logic [7:0] d, input int exp_n,
                               input logic [7:0] exp_cs, input logic [7:0] exp_data);
        int         low = 0;
        int         pulses = 0;
        int         cs_bad = 0;
        logic [7:0] wd = 8'h00;
        put(a, w, d);
        step();
        for (int i = 0; i < 20; i++) begin
            if (slot_we_o) begin
                pulses++;
                wd = slot_wdata_o;
            end
            if (slot_cs_o != exp_cs) cs_bad++;
            if (cpu_rdy_o) break;
            low++;
            step();
        end
        check({tag, "_rdy_low"}, 16'(low), 16'(exp_n));
        check({tag, "_cs_held"}, 16'(cs_bad), 16'd0);
        check({tag, "_we_pulses"}, 16'(pulses), w ? 16'd1 : 16'd0);
        if (w) check({tag, "_wdata"}, {8'h00, wd}, {8'h00, exp_data});
        else   check({tag, "_rdata"}, {8'h00, cpu_rdata_o}, {8'h00, exp_data});
        put(16'h0100, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N_SLOTS; k++) slot_rdata_i[8*k +: 8] = 8'h50 + 8'(k);
        slot_rdata_i[31:24] = 8'hA5;

        step(); step(); step();
        rst_i = 1'b0;
        check("rst_rdy", {15'd0, cpu_rdy_o}, 16'd1);
        check("rst_rom_en", {15'd0, rom_en_o}, 16'd1);
        check("rst_slot_cs", {8'd0, slot_cs_o}, 16'h0000);
        check("rst_slot_we", {15'd0, slot_we_o}, 16'd0);
        check("rst_slot_addr", {8'd0, slot_addr_o}, 16'h0000);
        check("rst_slot_wdata", {8'd0, slot_wdata_o}, 16'h0000);
        check("rst_rdata_ram", {8'd0, cpu_rdata_o}, 16'h0011);

        // ROM / RAM decode and ROMCTL
        put(16'hFFFC, 1'b0, 8'h00);
        check("vec_rom_cs", {15'd0, rom_cs_o}, 16'd1);
        check("vec_ram_cs", {15'd0, ram_cs_o}, 16'd0);
        step();
        check("vec_rdata", {8'd0, cpu_rdata_o}, 16'h0022);
        put(16'hE000, 1'b0, 8'h00);
        check("e000_rom_cs_en", {15'd0, rom_cs_o}, 16'd1);
        step();
        put(16'hFE05, 1'b0, 8'h00);
        check("io_no_ram", {14'd0, ram_cs_o, rom_cs_o}, 16'd0);
        put(16'h0002, 1'b1, 8'h01);
        check("reg_wr_ram_cs", {15'd0, ram_cs_o}, 16'd1);
        step();
        cpu_we_i = 1'b0;
        check("romctl_rom_en", {15'd0, rom_en_o}, 16'd0);
        put(16'hE000, 1'b0, 8'h00);
        check("e000_ram_cs", {15'd0, ram_cs_o}, 16'd1);
        check("e000_rom_cs", {15'd0, rom_cs_o}, 16'd0);
        step();
        check("e000_rdata", {8'd0, cpu_rdata_o}, 16'h0011);
        put(16'hFFFC, 1'b0, 8'h00);
        check("vec_still_rom", {15'd0, rom_cs_o}, 16'd1);
        step();
        put(16'h0002, 1'b0, 8'h00);
        step();
        check("romctl_read", {8'd0, cpu_rdata_o}, 16'h0001);

        // Banked slot read and back-to-back bank change
        wr(16'h0000, 8'h03);
        put(16'hFE05, 1'b0, 8'h00);
        step();
        check("slot3_cs", {8'd0, slot_cs_o}, 16'h0008);
        check("slot3_addr", {8'd0, slot_addr_o}, 16'h0005);
        check("slot3_rdata", {8'd0, cpu_rdata_o}, 16'h00A5);
        check("slot3_no_we", {15'd0, slot_we_o}, 16'd0);
        wr(16'h0000, 8'h01);
        put(16'hFE07, 1'b1, 8'h77);
        step();
        cpu_we_i = 1'b0;
        check("b2b_cs", {8'd0, slot_cs_o}, 16'h0002);
        check("b2b_we", {15'd0, slot_we_o}, 16'd1);
        check("b2b_wdata", {8'd0, slot_wdata_o}, 16'h0077);
        check("b2b_addr", {8'd0, slot_addr_o}, 16'h0007);

        // Wait states
        wr(16'h0000, 8'h02);
        slot_access("w2_write", 16'hFE10, 1'b1, 8'h5A, EXP_W2, 8'h04, 8'h5A);
        slot_access("w2_read", 16'hFE10, 1'b0, 8'h00, EXP_W2, 8'h04, 8'h52);
        wr(16'h0000, 8'h05);
        slot_access("w5_max", 16'hFE20, 1'b0, 8'h00, EXP_W5, 8'h20, 8'h55);

        // Bank boundaries and unmapped banks
        wr(16'h0000, 8'h07);
        put(16'hFE00, 1'b0, 8'h00);
        step();
        check("bank7_cs", {8'd0, slot_cs_o}, 16'h0080);
        check("bank7_rdata", {8'd0, cpu_rdata_o}, 16'h0057);
        put(16'h0003, 1'b0, 8'h00);
        step();
        check("status_clean", {8'd0, cpu_rdata_o}, 16'h0000);
        wr(16'h0000, 8'h02);
        wr(16'h0001, 8'h01);
        put(16'hFE00, 1'b0, 8'h00);
        step();
        check("bankh_unmapped", {8'd0, cpu_rdata_o}, 16'h00FF);
        wr(16'h0001, 8'h00);
        wr(16'h0003, 8'h01);
        wr(16'h0000, 8'h09);
        put(16'hFE00, 1'b0, 8'h00);
        step();
        check("unm_rdata", {8'd0, cpu_rdata_o}, 16'h00FF);
        check("unm_cs", {8'd0, slot_cs_o}, 16'h0000);
        put(16'hFE00, 1'b1, 8'h33);
        step();
        cpu_we_i = 1'b0;
        check("unm_we_dropped", {15'd0, slot_we_o}, 16'd0);
        put(16'h0003, 1'b0, 8'h00);
        step();
        check("status_set", {8'd0, cpu_rdata_o}, 16'h0001);
        wr(16'h0003, 8'h01);
        put(16'h0003, 1'b0, 8'h00);
        step();
        check("status_cleared", {8'd0, cpu_rdata_o}, 16'h0000);

        // Reset during the second wait cycle
        wr(16'h0000, 8'h02);
        put(16'hFE10, 1'b0, 8'h00);
        step();
        step();
        check("mid_rdy", {15'd0, cpu_rdy_o}, {15'd0, EXP_MID});
        check("mid_cs", {8'd0, slot_cs_o}, 16'h0004);
        rst_i = 1'b1;
        #1;
        check("arst_rdy", {15'd0, cpu_rdy_o}, 16'd1);
        check("arst_cs", {8'd0, slot_cs_o}, 16'h0000);
        check("arst_rom_en", {15'd0, rom_en_o}, 16'd1);
        put(16'h0000, 1'b0, 8'h00);
        step();
        rst_i = 1'b0;
        step();
        check("arst_bank", {8'd0, cpu_rdata_o}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_fabric.md
# io_fabric

Parametrised IO bus fabric for the nano6502 SoC, and the successor to the fixed address decoder and priority read mux. It decodes CPU addresses into RAM, ROM and N banked IO slots, and holds the bank, ROM-control and status registers. It registers the peripheral-side address, write strobe and write data, and returns read data through a registered one-hot mux. New relative to the fixed decoder: configurable slot count, per-slot wait states via CPU RDY, and unmapped-bank detection.

## Interface
- N_SLOTS, 8: IO slots addressable through the bank register (1..16).
- WAIT_W, 3: width of each per-slot wait count.
- SLOT_WAIT, all zero: N_SLOTS*WAIT_W packed vector; field k is the number of wait cycles for slot k.
- IO_PAGE, 8'hFE: high address byte of the IO window.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- cpu_addr_i  in  16  CPU address bus
- cpu_we_i  in  1  CPU write enable
- cpu_wdata_i  in  8  CPU data out
- cpu_rdata_o  out  8  CPU data in
- cpu_rdy_o  out  1  CPU RDY
- ram_cs_o  out  1  RAM select (combinational)
- ram_rdata_i  in  8  RAM read data
- rom_cs_o  out  1  ROM select (combinational)
- rom_rdata_i  in  8  ROM read data
- slot_cs_o  out  N_SLOTS  one-hot slot select (registered)
- slot_we_o  out  1  slot write strobe (registered)
- slot_addr_o  out  8  slot register offset (registered)
- slot_wdata_o  out  8  slot write data (registered)
- slot_rdata_i  in  N_SLOTS*8  slot read data, slot k at [8k+7:8k]
- rom_en_o  out  1  ROM mapped at E000–FDFF

## Operation
- Decode of cpu_addr_i:
  - 0000–0003: fabric registers.
  - FF00–FFFF: ROM always.
  - E000–FDFF (excluding the IO page): ROM if rom_en_o, else RAM.
  - IO_PAGE:00–FF: slot indexed by the bank register.
  - All other addresses: RAM.
- Fabric registers:
  - 0000 BANK_L, 0001 BANK_H.
  - 0002 ROMCTL, bit0: 0 = ROM, 1 = RAM.
  - 0003 STATUS, bit0 = sticky unmapped flag, write-1-to-clear. Other bits read 0.
  - Writes to 0000–0003 also go to RAM. Reads return the register value.
- Bank value ≥ N_SLOTS is unmapped:
  - no slot_cs_o bit is set;
  - reads return 8'hFF;
  - writes are dropped;
  - STATUS.bit0 is set on the access cycle.
- Source select for reads is registered (sel_q); cpu_rdata_o is muxed from sel_q in the cycle after the address. This matches the CPU's synchronous-read expectation.
- Wait FSM, states IDLE and WAIT:
  - IDLE → WAIT on a slot access with SLOT_WAIT[k] = n > 0. Load counter with n and drive cpu_rdy_o low.
  - WAIT: decrement each cycle. At 1, raise cpu_rdy_o and return to IDLE.
  - slot_cs_o stays asserted for the whole access.
  - slot_we_o pulses only on the first registered cycle of the access.
  - Read data is taken from the final cycle.
- Reset values:
  - BANK = 0, ROMCTL = 0 (rom_en_o = 1), STATUS = 0.
  - slot_cs_o = 0, slot_we_o = 0, slot_addr_o = 0, slot_wdata_o = 0.
  - cpu_rdy_o = 1, FSM in IDLE, sel_q = RAM.

## Timing
- ram_cs_o and rom_cs_o are combinational with cpu_addr_i, in the same cycle.
- Slot-side outputs lag cpu_addr_i by exactly 1 cycle.
- Read data for zero-wait sources reaches cpu_rdata_o 1 cycle after the address.
- A slot with n waits: cpu_rdy_o is low for n cycles, starting the cycle after the address. Total access is n+1 cycles.
- A write to BANK_L/BANK_H takes effect for decodes from the next cycle. A back-to-back IO access uses the new bank.
- A write-1 to STATUS.bit0 in the same cycle as a new unmapped access leaves the flag set. Set wins.
- Asserting rst_i mid-wait aborts the access immediately: FSM to IDLE, cpu_rdy_o = 1.
- The wait counter does not wrap: n = 2^WAIT_W − 1 is the maximum.

## Configuration
- IO_FABRIC_WAIT_EN defined: wait FSM and cpu_rdy_o stretching are active.
- IO_FABRIC_WAIT_EN undefined: cpu_rdy_o is tied 1, SLOT_WAIT is ignored, and every access is 1 cycle. The FSM and counter are not synthesised.

## Structure
- Package io_fabric_pkg holds:
  - address constants (register offsets 0–3, ROM window bounds, vector page);
  - source-select enum (RAM, ROM, REG, SLOT, UNMAPPED);
  - wait FSM state enum.
- Sub-module io_wait_ctrl holds the counter and FSM. It takes a start pulse and n, and outputs rdy. It is instantiated only under IO_FABRIC_WAIT_EN.

## Test plan
- Reset, then read FFFC → rom_cs_o = 1. Write 01 to 0002, then read E000 → ram_cs_o = 1 and rom_en_o = 0. Read FFFC → still ROM.
- Write BANK = 0003, then read FE05 → slot_cs_o = 8'b0000_1000 and slot_addr_o = 05 one cycle later. Slot 3 drives A5 → cpu_rdata_o = A5.
- SLOT_WAIT[2] = 3, bank 2, write 5A to FE10 → cpu_rdy_o low for exactly 3 cycles, single slot_we_o pulse with slot_wdata_o = 5A.
- Bank = 0009 with N_SLOTS = 8, read FE00 → cpu_rdata_o = FF, no slot_cs_o, STATUS = 01. Write 01 to 0003 → STATUS = 00.
- Assert rst_i during the 2nd wait cycle → cpu_rdy_o = 1, slot_cs_o = 0, and BANK/ROMCTL reset asynchronously.
- Build without IO_FABRIC_WAIT_EN, repeat the wait scenario → cpu_rdy_o constantly 1 and the access completes in 1 cycle.
